// File: rtl/ctrl_pkg.sv
// Shared controller/datapath definitions: FSM states, opcodes and the
// bundle of control strobes that the state decoder produces.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_DEC   = 3'd3,
    S_LDA   = 3'd4,
    S_STA   = 3'd5,
    S_ADD   = 3'd6,
    S_JMP   = 3'd7
  } state_e;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef struct packed {
    logic rd_mem;
    logic wr_mem;
    logic ir_on_adr;
    logic pc_on_adr;
    logic data_on_dbus;
    logic dbus_on_data;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic clr_pc;
    logic pass;
    logic add;
    logic alu_on_dbus;
    logic busy;
  } ctrl_t;

  function automatic logic is_exec(state_e s);
    return (s == S_LDA) || (s == S_STA) ||
           (s == S_ADD) || (s == S_JMP);
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Moore output decoder: maps the state register onto the 15 control
// strobes with no dependence on any other input.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e state,
  output logic   rd_mem,
  output logic   wr_mem,
  output logic   ir_on_adr,
  output logic   pc_on_adr,
  output logic   data_on_dbus,
  output logic   dbus_on_data,
  output logic   ld_ir,
  output logic   ld_ac,
  output logic   ld_pc,
  output logic   inc_pc,
  output logic   clr_pc,
  output logic   pass,
  output logic   add,
  output logic   alu_on_dbus,
  output logic   busy
);

  ctrl_t c;

  always_comb begin
    c = '0;
    unique case (state)
      S_RST: c.clr_pc = 1'b1;
      S_IDLE: c = '0;
      S_FETCH: begin
        c.pc_on_adr    = 1'b1;
        c.rd_mem       = 1'b1;
        c.data_on_dbus = 1'b1;
        c.ld_ir        = 1'b1;
      end
      S_DEC: c.inc_pc = 1'b1;
      S_LDA: begin
        c.ir_on_adr    = 1'b1;
        c.rd_mem       = 1'b1;
        c.data_on_dbus = 1'b1;
        c.pass         = 1'b1;
        c.ld_ac        = 1'b1;
      end
      S_STA: begin
        c.ir_on_adr    = 1'b1;
        c.pass         = 1'b1;
        c.alu_on_dbus  = 1'b1;
        c.dbus_on_data = 1'b1;
        c.wr_mem       = 1'b1;
      end
      S_ADD: begin
        c.ir_on_adr    = 1'b1;
        c.rd_mem       = 1'b1;
        c.data_on_dbus = 1'b1;
        c.add          = 1'b1;
        c.ld_ac        = 1'b1;
      end
      S_JMP: begin
        c.ir_on_adr = 1'b1;
        c.ld_pc     = 1'b1;
      end
      default: c = '0;
    endcase
    c.busy = (state != S_IDLE);
  end

  assign rd_mem       = c.rd_mem;
  assign wr_mem       = c.wr_mem;
  assign ir_on_adr    = c.ir_on_adr;
  assign pc_on_adr    = c.pc_on_adr;
  assign data_on_dbus = c.data_on_dbus;
  assign dbus_on_data = c.dbus_on_data;
  assign ld_ir        = c.ld_ir;
  assign ld_ac        = c.ld_ac;
  assign ld_pc        = c.ld_pc;
  assign inc_pc       = c.inc_pc;
  assign clr_pc       = c.clr_pc;
  assign pass         = c.pass;
  assign add          = c.add;
  assign alu_on_dbus  = c.alu_on_dbus;
  assign busy         = c.busy;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller FSM with retired-instruction counter.
// Define CTRL_STEP_EN for single-step mode (adds the step input).
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
`ifdef CTRL_STEP_EN
  input  logic       step,
`endif
  input  logic [1:0] op_code,
  input  logic       run,
  input  logic       mem_ready,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       data_on_dbus,
  output logic       dbus_on_data,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       pass,
  output logic       add,
  output logic       alu_on_dbus,
  output logic       busy,
  output logic [7:0] instr_count
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done;
  logic       go;
  state_e     after_exec;

`ifdef CTRL_STEP_EN
  assign go         = step;
  assign after_exec = S_IDLE;
`else
  assign go         = run;
  assign after_exec = run ? S_FETCH : S_IDLE;
`endif

  // JMP never touches memory, so it completes unconditionally
  always_comb begin
    done = 1'b0;
    if (is_exec(state_q))
      done = (state_q == S_JMP) ? 1'b1 : mem_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:   state_d = S_IDLE;
      S_IDLE:  state_d = go ? S_FETCH : S_IDLE;
      S_FETCH: state_d = mem_ready ? S_DEC : S_FETCH;
      S_DEC: begin
        unique case (op_code)
          OP_LDA: state_d = S_LDA;
          OP_STA: state_d = S_STA;
          OP_ADD: state_d = S_ADD;
          OP_JMP: state_d = S_JMP;
          default: state_d = S_LDA;
        endcase
      end
      default: state_d = done ? after_exec : state_q;
    endcase
  end

  assign cnt_d = cnt_q + {7'd0, done};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_count = cnt_q;

  ctrl_decode u_decode (
    .state        (state_q),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .ir_on_adr    (ir_on_adr),
    .pc_on_adr    (pc_on_adr),
    .data_on_dbus (data_on_dbus),
    .dbus_on_data (dbus_on_data),
    .ld_ir        (ld_ir),
    .ld_ac        (ld_ac),
    .ld_pc        (ld_pc),
    .inc_pc       (inc_pc),
    .clr_pc       (clr_pc),
    .pass         (pass),
    .add          (add),
    .alu_on_dbus  (alu_on_dbus),
    .busy         (busy)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a
// randomized instruction stream checked against a per-instruction trace model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [1:0] op_code;
  logic       run;
  logic       mem_ready;
  logic       rd_mem, wr_mem, ir_on_adr, pc_on_adr;
  logic       data_on_dbus, dbus_on_data;
  logic       ld_ir, ld_ac, ld_pc, inc_pc, clr_pc;
  logic       pass, add, alu_on_dbus, busy;
  logic [7:0] instr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk          (clk),
    .reset        (reset),
`ifdef CTRL_STEP_EN
    .step         (step),
`endif
    .op_code      (op_code),
    .run          (run),
    .mem_ready    (mem_ready),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .ir_on_adr    (ir_on_adr),
    .pc_on_adr    (pc_on_adr),
    .data_on_dbus (data_on_dbus),
    .dbus_on_data (dbus_on_data),
    .ld_ir        (ld_ir),
    .ld_ac        (ld_ac),
    .ld_pc        (ld_pc),
    .inc_pc       (inc_pc),
    .clr_pc       (clr_pc),
    .pass         (pass),
    .add          (add),
    .alu_on_dbus  (alu_on_dbus),
    .busy         (busy),
    .instr_count  (instr_count)
  );

  // Output bit weights, order matches obs()
  localparam logic [14:0] RD   = 15'h4000;
  localparam logic [14:0] WR   = 15'h2000;
  localparam logic [14:0] IRA  = 15'h1000;
  localparam logic [14:0] PCA  = 15'h0800;
  localparam logic [14:0] DDB  = 15'h0400;
  localparam logic [14:0] DBD  = 15'h0200;
  localparam logic [14:0] LIR  = 15'h0100;
  localparam logic [14:0] LAC  = 15'h0080;
  localparam logic [14:0] LPC  = 15'h0040;
  localparam logic [14:0] INC  = 15'h0020;
  localparam logic [14:0] CLR  = 15'h0010;
  localparam logic [14:0] PAS  = 15'h0008;
  localparam logic [14:0] ADF  = 15'h0004;
  localparam logic [14:0] ALU  = 15'h0002;
  localparam logic [14:0] BSY  = 15'h0001;

  localparam logic [14:0] V_RST   = CLR | BSY;
  localparam logic [14:0] V_IDLE  = 15'h0000;
  localparam logic [14:0] V_FETCH = PCA | RD | DDB | LIR | BSY;
  localparam logic [14:0] V_DEC   = INC | BSY;
  localparam logic [14:0] V_LDA   = IRA | RD | DDB | PAS | LAC | BSY;
  localparam logic [14:0] V_STA   = IRA | PAS | ALU | DBD | WR | BSY;
  localparam logic [14:0] V_ADD   = IRA | RD | DDB | ADF | LAC | BSY;
  localparam logic [14:0] V_JMP   = IRA | LPC | BSY;

  function automatic logic [14:0] obs();
    return {rd_mem, wr_mem, ir_on_adr, pc_on_adr, data_on_dbus,
            dbus_on_data, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc,
            pass, add, alu_on_dbus, busy};
  endfunction

  function automatic logic [14:0] exec_vec(logic [1:0] op);
    case (op)
      2'b00:   return V_LDA;
      2'b01:   return V_STA;
      2'b10:   return V_ADD;
      default: return V_JMP;
    endcase
  endfunction

  // Leaves the DUT in IDLE, observed on a falling edge, counter cleared
  task automatic apply_reset();
    reset = 1'b1;
    run = 1'b0;
    step = 1'b0;
    mem_ready = 1'b1;
    op_code = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (obs() !== V_IDLE || instr_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_idle: got %h/%0d want %h/0",
               obs(), instr_count, V_IDLE);
    end
    run = 1'b1; op_code = 2'b00; mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    op_code = 2'b01;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== V_STA || instr_count !== 8'd1) begin
      bad++;
      $display("FAIL reset_pre_sta: got %h/%0d want %h/1",
               obs(), instr_count, V_STA);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== V_RST || instr_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_in_sta: got %h/%0d want %h/0",
               obs(), instr_count, V_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    total++;
    if (obs() !== V_RST) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", obs(), V_RST);
    end
    @(negedge clk);
    total++;
    if (obs() !== V_IDLE || instr_count !== 8'd0 || wr_mem !== 1'b0) begin
      bad++;
      $display("FAIL reset_after: got %h/%0d want %h/0",
               obs(), instr_count, V_IDLE);
    end
  endtask

  task automatic test_fetch_exec();
    logic [14:0] want [3];
    want[0] = V_FETCH; want[1] = V_DEC; want[2] = V_LDA;
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; op_code = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) run = 1'b0;
      total++;
      if (obs() !== want[i]) begin
        bad++;
        $display("FAIL fetch_exec_c%0d: got %h want %h", i, obs(), want[i]);
      end
    end
    @(negedge clk);
    total++;
    if (obs() !== V_IDLE || instr_count !== 8'd1) begin
      bad++;
      $display("FAIL fetch_exec_done: got %h/%0d want %h/1",
               obs(), instr_count, V_IDLE);
    end
  endtask

  task automatic test_wait_states();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; op_code = 2'b10;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (obs() !== V_ADD || instr_count !== 8'd0) begin
        bad++;
        $display("FAIL add_wait_c%0d: got %h/%0d want %h/0",
                 k, obs(), instr_count, V_ADD);
      end
      mem_ready = (k == 4);
      run = (k != 4);
    end
    @(negedge clk);
    total++;
    if (obs() !== V_IDLE || instr_count !== 8'd1) begin
      bad++;
      $display("FAIL add_wait_done: got %h/%0d want %h/1",
               obs(), instr_count, V_IDLE);
    end
  endtask

  task automatic test_jump();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; op_code = 2'b11;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== V_JMP) begin
      bad++;
      $display("FAIL jmp_state: got %h want %h", obs(), V_JMP);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== V_FETCH || instr_count !== 8'd1) begin
      bad++;
      $display("FAIL jmp_next: got %h/%0d want %h/1",
               obs(), instr_count, V_FETCH);
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; op_code = 2'b11;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== V_FETCH || instr_count !== 8'(i)) begin
        bad++;
        $display("FAIL wrap_i%0d: got %h/%0d want %h/%0d",
                 i, obs(), instr_count, V_FETCH, i % 256);
      end
      repeat (2) @(negedge clk);
      if (i == 255) run = 1'b0;
    end
    @(negedge clk);
    total++;
    if (obs() !== V_IDLE || instr_count !== 8'd0) begin
      bad++;
      $display("FAIL wrap_end: got %h/%0d want %h/0",
               obs(), instr_count, V_IDLE);
    end
  endtask

  task automatic test_run_drop();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; op_code = 2'b01;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== V_STA) begin
      bad++;
      $display("FAIL run_drop_hold: got %h want %h", obs(), V_STA);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== V_IDLE || busy !== 1'b0 || instr_count !== 8'd1) begin
      bad++;
      $display("FAIL run_drop_done: got %h/%0d want %h/1",
               obs(), instr_count, V_IDLE);
    end
  endtask

  // Builds each instruction's expected trace from the opcode and the
  // chosen wait counts, then steps the DUT through it
  task automatic test_random();
    int fw, ew, nidle, retired;
    logic [1:0] opi;
    logic rn;
    retired = 0;
    apply_reset();
    run = 1'b1; mem_ready = 1'($urandom); op_code = 2'($urandom);
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      fw = $urandom_range(0, 3);
      opi = 2'($urandom);
      ew = (opi == 2'b11) ? 0 : $urandom_range(0, 3);
      rn = ($urandom_range(0, 3) != 0);
      for (int k = 0; k <= fw; k++) begin
        total++;
        if (obs() !== V_FETCH || instr_count !== 8'(retired)) begin
          bad++;
          $display("FAIL rand_fetch_i%0d: got %h/%0d want %h/%0d",
                   i, obs(), instr_count, V_FETCH, retired % 256);
        end
        mem_ready = (k == fw);
        op_code = 2'($urandom);
        run = 1'($urandom);
        @(negedge clk);
      end
      total++;
      if (obs() !== V_DEC) begin
        bad++;
        $display("FAIL rand_dec_i%0d: got %h want %h", i, obs(), V_DEC);
      end
      op_code = opi;
      mem_ready = 1'($urandom);
      run = 1'($urandom);
      @(negedge clk);
      for (int k = 0; k <= ew; k++) begin
        total++;
        if (obs() !== exec_vec(opi)) begin
          bad++;
          $display("FAIL rand_exec_i%0d: got %h want %h",
                   i, obs(), exec_vec(opi));
        end
        mem_ready = (opi == 2'b11) ? 1'($urandom) : (k == ew);
        op_code = 2'($urandom);
        run = (k == ew) ? rn : 1'($urandom);
        @(negedge clk);
      end
      retired++;
      if (!rn) begin
        nidle = $urandom_range(0, 2);
        for (int j = 0; j <= nidle; j++) begin
          total++;
          if (obs() !== V_IDLE || instr_count !== 8'(retired)) begin
            bad++;
            $display("FAIL rand_idle_i%0d: got %h/%0d want %h/%0d",
                     i, obs(), instr_count, V_IDLE, retired % 256);
          end
          run = (j == nidle);
          mem_ready = 1'($urandom);
          @(negedge clk);
        end
      end
    end
  endtask

`ifdef CTRL_STEP_EN
  task automatic test_step();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; op_code = 2'b00;
    for (int n = 0; n < 2; n++) begin
      repeat (2) @(negedge clk);
      total++;
      if (obs() !== V_IDLE || instr_count !== 8'(n)) begin
        bad++;
        $display("FAIL step_idle_%0d: got %h/%0d want %h/%0d",
                 n, obs(), instr_count, V_IDLE, n);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      total++;
      if (obs() !== V_FETCH) begin
        bad++;
        $display("FAIL step_fetch_%0d: got %h want %h", n, obs(), V_FETCH);
      end
      repeat (3) @(negedge clk);
    end
    total++;
    if (obs() !== V_IDLE || instr_count !== 8'd2) begin
      bad++;
      $display("FAIL step_end: got %h/%0d want %h/2",
               obs(), instr_count, V_IDLE);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    run = 1'b0;
    step = 1'b0;
    mem_ready = 1'b0;
    op_code = 2'b00;
`ifdef CTRL_STEP_EN
    test_step();
`else
    test_reset();
    test_fetch_exec();
    test_wait_states();
    test_jump();
    test_run_drop();
    test_wrap();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
